// File: rtl/rc5_scan_pkg.sv
// Shared types and constants for the rc5 scan/validation path.
// Field offsets and strobe indices describe the default 168-bit input chain layout.
package rc5_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ARMED    = 2'd1,
    S_CAPTURED = 2'd2
  } state_t;

  localparam int unsigned DEF_IN_W    = 168;
  localparam int unsigned DEF_OUT_W   = 33;
  localparam int unsigned DEF_PULSE_W = 3;
  localparam int unsigned DEF_TIMEOUT = 1024;

  localparam int unsigned KEY_LSB = 0;
  localparam int unsigned DIN_LSB = 128;
  localparam int unsigned NR_LSB  = 160;

  localparam int unsigned LOAD_KEY  = 0;
  localparam int unsigned START_ENC = 1;
  localparam int unsigned START_DEC = 2;

endpackage

// File: rtl/rc5_scan_shreg.sv
// Generic shift register with parallel load; load has priority over shift.
module rc5_scan_shreg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst)       q <= '0;
    else if (load)  q <= load_val;
    else if (shift) q <= {q[W-2:0], sin};
  end

endmodule

// File: rtl/rc5_scan_ctrl.sv
// Bit-serial scan controller between tester pins and the rc5 core: input chain
// apply with strobes, result capture with timeout, serial readout.
module rc5_scan_ctrl
  import rc5_scan_pkg::*;
#(
  parameter int unsigned IN_W    = DEF_IN_W,
  parameter int unsigned OUT_W   = DEF_OUT_W,
  parameter int unsigned PULSE_W = DEF_PULSE_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scan_en,
  input  logic                    scan_in,
  input  logic                    begin_validate,
  output logic                    scan_out,
  output logic [IN_W-PULSE_W-1:0] core_in,
  output logic [PULSE_W-1:0]      core_strobe,
  input  logic [OUT_W-2:0]        core_out,
  input  logic                    core_done,
  output logic                    busy,
  output logic                    len_err,
  output logic                    to_err
);

  localparam int unsigned CW = $clog2(IN_W + 2);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t                  state;
  logic                    bv_q;
  logic [CW-1:0]           cnt;
  logic [TW-1:0]           timer;
  logic [IN_W-1:0]         sin_q;
  logic [OUT_W-1:0]        sout_q;
  logic [OUT_W-2:0]        sout_unused;
  logic [IN_W-PULSE_W-1:0] core_in_q;
  logic [PULSE_W-1:0]      strobe_q;

  logic rise, fall, sin_shift, cnt_ok, armed_chk, cap_done, cap_to, sout_load;
  logic [OUT_W-1:0] sout_val;

  always_comb begin
    rise      = begin_validate & ~bv_q;
    fall      = ~begin_validate & bv_q;
    sin_shift = scan_en & ~begin_validate;
    cnt_ok    = (cnt == CW'(IN_W));
    // A falling begin_validate implies it is low, so no capture on that edge.
    armed_chk = (state == S_ARMED) & begin_validate;
    cap_done  = armed_chk & core_done;
    cap_to    = armed_chk & ~core_done & (timer == TW'(TIMEOUT - 1));
    sout_load = cap_done | cap_to;
    sout_val  = '0;
    if (cap_done) sout_val = {core_done, core_out};
  end

  rc5_scan_shreg #(.W(IN_W)) u_sin (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val ('0),
    .shift    (sin_shift),
    .sin      (scan_in),
    .q        (sin_q)
  );

  rc5_scan_shreg #(.W(OUT_W)) u_sout (
    .clk      (clk),
    .rst      (rst),
    .load     (sout_load),
    .load_val (sout_val),
    .shift    (scan_en),
    .sin      (1'b0),
    .q        (sout_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      bv_q      <= 1'b0;
      cnt       <= '0;
      timer     <= '0;
      core_in_q <= '0;
      strobe_q  <= '0;
      len_err   <= 1'b0;
      to_err    <= 1'b0;
    end else begin
      bv_q     <= begin_validate;
      strobe_q <= '0;
      if (sin_shift && cnt != CW'(IN_W + 1)) cnt <= cnt + CW'(1);
      if (fall) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (rise) begin
              if (cnt_ok) begin
                core_in_q <= sin_q[IN_W-PULSE_W-1:0];
                strobe_q  <= sin_q[IN_W-1:IN_W-PULSE_W];
                timer     <= '0;
                state     <= S_ARMED;
                len_err   <= 1'b0;
                to_err    <= 1'b0;
              end else begin
                len_err <= 1'b1;
              end
            end
          end
          S_ARMED: begin
            if (cap_done) begin
              state <= S_CAPTURED;
            end else if (cap_to) begin
              to_err <= 1'b1;
              state  <= S_CAPTURED;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sout_unused = sout_q[OUT_W-2:0];
  assign scan_out    = sout_q[OUT_W-1];
  assign core_in     = core_in_q;
  assign core_strobe = strobe_q;
  assign busy        = (state == S_ARMED);

endmodule
